gbc_dma_mover: RTL and testbench
================================

Name: gbc_dma_mover

Overview:
Datapath stage directly downstream of the GBC HDMA/GDMA register controller (FF51-FF55). It consumes the controller's hdma_rd, hdma_active and source/target address strobes. For each new byte address it performs one source bus read and one VRAM write. It also drives the CPU stall and tracks transfer progress. The controller owns timing (one address per 4 clk); this block owns the per-byte bus sequence.

Parameters:
RD_LATENCY, 1, clk cycles from bus_rd to valid bus_rdata (legal 1..2)
CNT_W, 12, width of bytes_done counter (max 0x800 bytes per transfer)

Ports:
clk  in  1  8 MHz system clock
reset  in  1  sync active-high reset
hdma_rd  in  1  controller requests byte moves
hdma_active  in  1  transfer phase in progress (CPU must halt)
hdma_source_addr  in  16  current byte source address
hdma_target_addr  in  16  current byte target address (8000-9FFF space)
vbk  in  1  VBK bit0, VRAM bank for writes
lcd_mode  in  2  STAT mode bits
bus_addr  out  16  source read address
bus_rd  out  1  source read strobe, 1 cycle
bus_rdata  in  8  source read data
vram_we  out  1  VRAM write strobe, 1 cycle
vram_addr  out  13  VRAM byte address
vram_bank  out  1  VRAM bank for this write
vram_wdata  out  8  write data
cpu_stall  out  1  halt CPU
busy  out  1  byte sequence in flight
bytes_done  out  CNT_W  bytes written in current transfer
overrun  out  1  sticky: new address arrived mid-sequence

Behaviour:
- Reset: all outputs 0; FSM IDLE; last_src latch = 16'hFFFF; valid_last = 0.
- Byte trigger: hdma_rd=1 and (valid_last=0 or hdma_source_addr != last_src). On trigger, latch src, tgt[12:0] and vbk; set last_src; valid_last=1.
- FSM IDLE -> REQ on trigger.
- REQ: bus_rd=1 for 1 cycle, bus_addr=mapped src; go to WAIT.
- WAIT: hold RD_LATENCY-1 cycles. With RD_LATENCY=1 it is 0 cycles, WAIT skipped.
- CAP: capture bus_rdata; go to WR.
- WR: vram_we=1 for 1 cycle with latched addr/bank/data; bytes_done+1 (saturating at all-ones); go to IDLE, or directly to REQ if a trigger is present that cycle.
- Latency: trigger to vram_we = 2+RD_LATENCY cycles (3 at default). This fits the 4-cycle byte slot.
- Source mapping: src[15:13]==3'b111 (E000-FFFF) reads A000-BFFF (clear bit 14). src in 8000-9FFF is not read: bus_rd stays 0 and data is 8'hFF. All other sources pass through unchanged.
- Target: vram_addr = tgt[12:0]; wraps within 8 KB naturally.
- Trigger in REQ/WAIT/CAP: abort current byte with no write, restart at REQ with new address, set overrun. overrun clears only on reset.
- hdma_rd falls mid-sequence: finish the current byte (write completes), then IDLE.
- cpu_stall = hdma_active | busy (combinational from registered busy). busy = FSM != IDLE.
- hdma_active rising edge: bytes_done=0 and valid_last=0, so an identical address on a new transfer re-triggers. Clear wins over same-cycle increment.
- hdma_rd low: valid_last=0 at the next byte boundary, so HDMA blocks in successive H-Blanks start fresh.

Optional Feature:
GBC_VRAM_MODE3_LOCK_EN. When defined, a WR-state write with lcd_mode==2'b11 is suppressed: vram_we=0, bytes_done is still incremented, and extra output port dropped_writes (8 bit, saturating, cleared with bytes_done) is incremented. When undefined, writes are never gated by lcd_mode and the port does not exist.

Decomposition:
- Shared package gbc_dma_pkg:
  - FSM state enum (IDLE, REQ, WAIT, CAP, WR)
  - VRAM_BASE 16'h8000, ECHO_MASK 16'hBFFF, OPEN_BUS 8'hFF
  - LCD_MODE_HBLANK 2'b00, LCD_MODE_XFER 2'b11
- One sub-module: gbc_dma_srcmap, the combinational source-address mapper plus VRAM-source detect. It is reusable by OAM DMA.

Test Plan:
- GDMA 0x20 bytes, src 2040, tgt 8200, vbk=1: 32 vram_we pulses, addr 0x0200..0x021F, bank 1, data equals memory model, bytes_done=0x020, overrun=0.
- Src E010: bus_addr=A010 on bus_rd; written data equals model[A010].
- Src 8800: no bus_rd pulse; vram_wdata=8'hFF.
- Address change 2 cycles after previous trigger: first byte has no vram_we, overrun=1 and stays 1 until reset.
- Reset asserted in CAP: next cycle all outputs 0 and no vram_we. Same address after reset triggers a fresh byte.
- GBC_VRAM_MODE3_LOCK_EN with lcd_mode=3 during WR: vram_we=0, dropped_writes=1, bytes_done increments.

Source files
------------

// File: rtl/gbc_dma_pkg.sv
// Shared types and constants for the GBC HDMA/GDMA byte mover and its source-address mapper.
package gbc_dma_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    CAP  = 3'd3,
    WR   = 3'd4
  } dma_state_e;

  localparam logic [15:0] VRAM_BASE       = 16'h8000;
  localparam logic [15:0] ECHO_MASK       = 16'hBFFF;
  localparam logic [15:0] REGION_MASK     = 16'hE000;
  localparam logic [7:0]  OPEN_BUS        = 8'hFF;
  localparam logic [1:0]  LCD_MODE_HBLANK = 2'b00;
  localparam logic [1:0]  LCD_MODE_XFER   = 2'b11;

  // True when the address lies in the 8 KB region starting at base.
  function automatic logic in_region(input logic [15:0] addr, input logic [15:0] base);
    return (addr & REGION_MASK) == base;
  endfunction

endpackage

// File: rtl/gbc_dma_srcmap.sv
// Combinational DMA source-address mapper: E000-FFFF folds onto A000-BFFF, and
// 8000-9FFF is flagged as a VRAM source that must not be read over the bus.
module gbc_dma_srcmap
  import gbc_dma_pkg::*;
(
  input  logic [15:0] src_i,
  output logic [15:0] bus_addr_o,
  output logic        vram_src_o
);

  // Map the source and detect VRAM-as-source.
  always_comb begin
    bus_addr_o = src_i;
    vram_src_o = in_region(src_i, VRAM_BASE);
    if (in_region(src_i, REGION_MASK)) begin
      bus_addr_o = src_i & ECHO_MASK;
    end else begin
      bus_addr_o = src_i;
    end
  end

endmodule

// File: rtl/gbc_dma_mover.sv
// Per-byte bus sequencer behind the GBC HDMA/GDMA controller: one source read and one
// VRAM write per new source address. Optional macro: GBC_VRAM_MODE3_LOCK_EN.
module gbc_dma_mover
  import gbc_dma_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hdma_rd,
  input  logic             hdma_active,
  input  logic [15:0]      hdma_source_addr,
  input  logic [15:0]      hdma_target_addr,
  input  logic             vbk,
  input  logic [1:0]       lcd_mode,
  output logic [15:0]      bus_addr,
  output logic             bus_rd,
  input  logic [7:0]       bus_rdata,
  output logic             vram_we,
  output logic [12:0]      vram_addr,
  output logic             vram_bank,
  output logic [7:0]       vram_wdata,
  output logic             cpu_stall,
  output logic             busy,
  output logic [CNT_W-1:0] bytes_done,
  output logic             overrun
`ifdef GBC_VRAM_MODE3_LOCK_EN
  ,
  output logic [7:0]       dropped_writes
`endif
);

  localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 2) ? 2'(RD_LATENCY - 2) : 2'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  dma_state_e state_q, state_d;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic [15:0]      bus_addr_q, bus_addr_d;
  logic             bus_rd_q, bus_rd_d;
  logic             vram_we_q, vram_we_d;
  logic [12:0]      vram_addr_q, vram_addr_d;
  logic             vram_bank_q, vram_bank_d;
  logic [7:0]       vram_wdata_q, vram_wdata_d;
  logic [12:0]      tgt_q, tgt_d;
  logic             bank_q, bank_d;
  logic             src_vram_q, src_vram_d;
  logic [15:0]      last_src_q, last_src_d;
  logic             valid_last_q, valid_last_d;
  logic [CNT_W-1:0] bytes_done_q, bytes_done_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             active_q;
`ifdef GBC_VRAM_MODE3_LOCK_EN
  logic             drop_q, drop_d;
  logic [7:0]       dropped_q, dropped_d;
`endif

  logic [15:0] src_map_s;
  logic        src_vram_s;
  logic        active_rise_s;
  logic        valid_last_eff_s;
  logic        trig_s;
  logic        mid_seq_s;
  logic        unused_s;

  gbc_dma_srcmap u_srcmap (
    .src_i      (hdma_source_addr),
    .bus_addr_o (src_map_s),
    .vram_src_o (src_vram_s)
  );

  // A new transfer forgets the last address in the same cycle it starts, so an
  // identical first address still triggers.
  assign active_rise_s    = hdma_active & ~active_q;
  assign valid_last_eff_s = valid_last_q & ~active_rise_s;
  assign trig_s           = hdma_rd & (~valid_last_eff_s | (hdma_source_addr != last_src_q));
  assign mid_seq_s        = (state_q == REQ) || (state_q == WAIT) || (state_q == CAP);
  assign unused_s         = ^{hdma_target_addr[15:13], lcd_mode};

  // Next-state, byte sequencing, progress counters and registered output values.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    bus_addr_d   = bus_addr_q;
    bus_rd_d     = 1'b0;
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_bank_d  = vram_bank_q;
    vram_wdata_d = vram_wdata_q;
    tgt_d        = tgt_q;
    bank_d       = bank_q;
    src_vram_d   = src_vram_q;
    last_src_d   = last_src_q;
    valid_last_d = valid_last_eff_s;
    bytes_done_d = bytes_done_q;
    overrun_d    = overrun_q;
`ifdef GBC_VRAM_MODE3_LOCK_EN
    drop_d       = 1'b0;
    dropped_d    = dropped_q;
`endif

    if (state_q == WR) begin
      if (bytes_done_q != {CNT_W{1'b1}}) begin
        bytes_done_d = bytes_done_q + CNT_ONE;
      end else begin
        bytes_done_d = bytes_done_q;
      end
`ifdef GBC_VRAM_MODE3_LOCK_EN
      if (drop_q && (dropped_q != 8'hFF)) begin
        dropped_d = dropped_q + 8'd1;
      end else begin
        dropped_d = dropped_q;
      end
`endif
    end else begin
      bytes_done_d = bytes_done_q;
    end

    if (active_rise_s) begin
      bytes_done_d = {CNT_W{1'b0}};
`ifdef GBC_VRAM_MODE3_LOCK_EN
      dropped_d    = 8'd0;
`endif
    end else begin
      valid_last_d = valid_last_eff_s;
    end

    // With hdma_rd low, the next byte boundary forgets the last address.
    if (!hdma_rd && ((state_q == IDLE) || (state_q == WR))) begin
      valid_last_d = 1'b0;
    end else begin
      valid_last_d = valid_last_d;
    end

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      REQ: begin
        if (RD_LATENCY > 1) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_INIT;
        end else begin
          state_d    = CAP;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 2'd0) begin
          state_d = CAP;
        end else begin
          wait_cnt_d = wait_cnt_q - 2'd1;
        end
      end
      CAP: begin
        state_d      = WR;
        vram_addr_d  = tgt_q;
        vram_bank_d  = bank_q;
        vram_wdata_d = src_vram_q ? OPEN_BUS : bus_rdata;
`ifdef GBC_VRAM_MODE3_LOCK_EN
        // lcd_mode is sampled as the write is launched into WR.
        vram_we_d    = (lcd_mode != LCD_MODE_XFER);
        drop_d       = (lcd_mode == LCD_MODE_XFER);
`else
        vram_we_d    = 1'b1;
`endif
      end
      WR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new address always restarts at REQ; mid-sequence it drops the pending byte.
    if (trig_s) begin
      state_d      = REQ;
      wait_cnt_d   = 2'd0;
      vram_we_d    = 1'b0;
      vram_addr_d  = vram_addr_q;
      vram_bank_d  = vram_bank_q;
      vram_wdata_d = vram_wdata_q;
`ifdef GBC_VRAM_MODE3_LOCK_EN
      drop_d       = 1'b0;
`endif
      bus_rd_d     = ~src_vram_s;
      bus_addr_d   = src_map_s;
      src_vram_d   = src_vram_s;
      tgt_d        = hdma_target_addr[12:0];
      bank_d       = vbk;
      last_src_d   = hdma_source_addr;
      valid_last_d = 1'b1;
      if (mid_seq_s) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else begin
      bus_rd_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 2'd0;
      bus_addr_q   <= 16'h0000;
      bus_rd_q     <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= 13'h0000;
      vram_bank_q  <= 1'b0;
      vram_wdata_q <= 8'h00;
      tgt_q        <= 13'h0000;
      bank_q       <= 1'b0;
      src_vram_q   <= 1'b0;
      last_src_q   <= 16'hFFFF;
      valid_last_q <= 1'b0;
      bytes_done_q <= {CNT_W{1'b0}};
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      active_q     <= 1'b0;
`ifdef GBC_VRAM_MODE3_LOCK_EN
      drop_q       <= 1'b0;
      dropped_q    <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_addr_q   <= bus_addr_d;
      bus_rd_q     <= bus_rd_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_bank_q  <= vram_bank_d;
      vram_wdata_q <= vram_wdata_d;
      tgt_q        <= tgt_d;
      bank_q       <= bank_d;
      src_vram_q   <= src_vram_d;
      last_src_q   <= last_src_d;
      valid_last_q <= valid_last_d;
      bytes_done_q <= bytes_done_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      active_q     <= hdma_active;
`ifdef GBC_VRAM_MODE3_LOCK_EN
      drop_q       <= drop_d;
      dropped_q    <= dropped_d;
`endif
    end
  end

  assign bus_addr   = bus_addr_q;
  assign bus_rd     = bus_rd_q;
  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_bank  = vram_bank_q;
  assign vram_wdata = vram_wdata_q;
  assign busy       = busy_q;
  assign cpu_stall  = hdma_active | busy_q;
  assign bytes_done = bytes_done_q;
  assign overrun    = overrun_q;
`ifdef GBC_VRAM_MODE3_LOCK_EN
  assign dropped_writes = dropped_q;
`endif

endmodule

// File: tb/tb_gbc_dma_mover.sv
// Scoreboard bench for gbc_dma_mover: expected bus reads and VRAM writes are queued
// as each byte is driven and checked as the DUT produces them.
module tb_gbc_dma_mover;

  localparam int unsigned CNT_W = 12;

  logic             clk = 1'b0;
  logic             reset;
  logic             hdma_rd;
  logic             hdma_active;
  logic [15:0]      hdma_source_addr;
  logic [15:0]      hdma_target_addr;
  logic             vbk;
  logic [1:0]       lcd_mode;
  logic [15:0]      bus_addr;
  logic             bus_rd;
  logic [7:0]       bus_rdata;
  logic             vram_we;
  logic [12:0]      vram_addr;
  logic             vram_bank;
  logic [7:0]       vram_wdata;
  logic             cpu_stall;
  logic             busy;
  logic [CNT_W-1:0] bytes_done;
  logic             overrun;
`ifdef GBC_VRAM_MODE3_LOCK_EN
  logic [7:0]       dropped_writes;
`endif

  typedef struct packed {
    logic [12:0] addr;
    logic        bank;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned wr_count = 0;
  wr_t         mon_w;
  logic [15:0] mon_a;

  gbc_dma_mover #(.RD_LATENCY(1), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .hdma_rd          (hdma_rd),
    .hdma_active      (hdma_active),
    .hdma_source_addr (hdma_source_addr),
    .hdma_target_addr (hdma_target_addr),
    .vbk              (vbk),
    .lcd_mode         (lcd_mode),
    .bus_addr         (bus_addr),
    .bus_rd           (bus_rd),
    .bus_rdata        (bus_rdata),
    .vram_we          (vram_we),
    .vram_addr        (vram_addr),
    .vram_bank        (vram_bank),
    .vram_wdata       (vram_wdata),
    .cpu_stall        (cpu_stall),
    .busy             (busy),
    .bytes_done       (bytes_done),
    .overrun          (overrun)
`ifdef GBC_VRAM_MODE3_LOCK_EN
    ,
    .dropped_writes   (dropped_writes)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Source memory model, one cycle read latency; junk when not reading.
  always @(posedge clk) begin
    bus_rdata <= bus_rd ? mem_byte(bus_addr) : 8'hEE;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus_rd === 1'b1) begin
      n_cmp++;
      if (exp_rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL bus_rd_unexpected: got read of %h, required no read", bus_addr);
      end else begin
        mon_a = exp_rd_q.pop_front();
        if (bus_addr !== mon_a) begin
          n_bad++;
          $display("FAIL bus_addr: got %h, required %h", bus_addr, mon_a);
        end
      end
    end
    if (vram_we === 1'b1) begin
      wr_count++;
      n_cmp++;
      if (exp_wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL vram_we_unexpected: got write a=%h b=%b d=%h, required no write",
                 vram_addr, vram_bank, vram_wdata);
      end else begin
        mon_w = exp_wr_q.pop_front();
        if ({vram_addr, vram_bank, vram_wdata} !== mon_w) begin
          n_bad++;
          $display("FAIL vram_write: got a=%h b=%b d=%h, required a=%h b=%b d=%h",
                   vram_addr, vram_bank, vram_wdata, mon_w.addr, mon_w.bank, mon_w.data);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic [15:0] src, input logic [15:0] tgt, input logic bank,
                            input int slot, input bit expect_wr);
    logic [15:0] mapped;
    wr_t         w;
    hdma_rd          = 1'b1;
    hdma_source_addr = src;
    hdma_target_addr = tgt;
    vbk              = bank;
    if (src[15:13] == 3'b100) begin
      w.data = 8'hFF;
    end else begin
      mapped = src;
      if (src[15:13] == 3'b111) mapped[14] = 1'b0;
      exp_rd_q.push_back(mapped);
      w.data = mem_byte(mapped);
    end
    w.addr = tgt[12:0];
    w.bank = bank;
    if (expect_wr) exp_wr_q.push_back(w);
    repeat (slot) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; hdma_rd = 1'b0; hdma_active = 1'b0; vbk = 1'b0; lcd_mode = 2'b00;
    hdma_source_addr = 16'h0000; hdma_target_addr = 16'h8000;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if ({bus_addr, bus_rd, vram_we, vram_addr, vram_bank, vram_wdata, cpu_stall, busy,
         bytes_done, overrun} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ba=%h rd=%b we=%b va=%h bk=%b wd=%h st=%b bz=%b bd=%h ov=%b, required all 0",
               bus_addr, bus_rd, vram_we, vram_addr, vram_bank, vram_wdata, cpu_stall, busy,
               bytes_done, overrun);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_gdma();
    int unsigned start = wr_count;
    hdma_active = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive_byte(16'h2040 + 16'(i), 16'h8200 + 16'(i), 1'b1, 4, 1'b1);
      if (i == 0) begin
        @(negedge clk);
        n_cmp++;
        if (cpu_stall !== 1'b1) begin
          n_bad++;
          $display("FAIL gdma_stall: got %b, required 1", cpu_stall);
        end
      end
    end
    hdma_rd = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if (bytes_done !== 12'h020) begin
      n_bad++;
      $display("FAIL gdma_bytes_done: got %h, required 020", bytes_done);
    end
    n_cmp++;
    if (wr_count - start !== 32 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL gdma_writes: got %0d writes, %0d/%0d outstanding, required 32, 0/0",
               wr_count - start, exp_wr_q.size(), exp_rd_q.size());
      exp_wr_q.delete(); exp_rd_q.delete();
    end
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL gdma_overrun: got %b, required 0", overrun);
    end
    hdma_active = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if ({cpu_stall, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL gdma_idle: got stall=%b busy=%b, required 0 0", cpu_stall, busy);
    end
  endtask

  task automatic test_echo_and_vram_src();
    hdma_active = 1'b1;
    drive_byte(16'hE010, 16'h8010, 1'b0, 4, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (bytes_done !== 12'h001) begin
      n_bad++;
      $display("FAIL echo_bytes_done: got %h, required 001", bytes_done);
    end
    drive_byte(16'h8800, 16'h9000, 1'b0, 4, 1'b1);
    hdma_rd = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if (bytes_done !== 12'h002 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL vram_src: got bd=%h, %0d/%0d outstanding, required 002, 0/0",
               bytes_done, exp_wr_q.size(), exp_rd_q.size());
      exp_wr_q.delete(); exp_rd_q.delete();
    end
    hdma_active = 1'b0;
    step();
  endtask

  task automatic test_hblank_restart();
    hdma_active = 1'b1;
    drive_byte(16'h5000, 16'h8400, 1'b0, 4, 1'b1);
    hdma_rd = 1'b0;
    repeat (4) step();
    drive_byte(16'h5000, 16'h8400, 1'b0, 4, 1'b1);
    hdma_rd = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if (bytes_done !== 12'h002 || exp_wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL hblank_restart: got bd=%h, %0d writes outstanding, required 002, 0",
               bytes_done, exp_wr_q.size());
      exp_wr_q.delete(); exp_rd_q.delete();
    end
    hdma_active = 1'b0;
    step();
  endtask

  task automatic test_overrun();
    drive_byte(16'h3000, 16'h8100, 1'b0, 2, 1'b0);
    drive_byte(16'h3100, 16'h8110, 1'b0, 4, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    drive_byte(16'h3200, 16'h8120, 1'b0, 4, 1'b1);
    hdma_rd = 1'b0;
    repeat (2) step();
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b1 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL overrun_sticky: got ov=%b, %0d/%0d outstanding, required 1, 0/0",
               overrun, exp_wr_q.size(), exp_rd_q.size());
      exp_wr_q.delete(); exp_rd_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    drive_byte(16'h4000, 16'h8300, 1'b0, 2, 1'b0);
    reset = 1'b1;
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus_rd, vram_we, cpu_stall, busy, bytes_done, overrun, vram_addr, vram_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got rd=%b we=%b st=%b bz=%b bd=%h ov=%b va=%h wd=%h, required all 0",
               bus_rd, vram_we, cpu_stall, busy, bytes_done, overrun, vram_addr, vram_wdata);
    end
    reset = 1'b0;
    drive_byte(16'h4000, 16'h8300, 1'b0, 4, 1'b1);
    hdma_rd = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || bytes_done !== 12'h001) begin
      n_bad++;
      $display("FAIL reset_refire: got bd=%h, %0d/%0d outstanding, required 001, 0/0",
               bytes_done, exp_wr_q.size(), exp_rd_q.size());
      exp_wr_q.delete(); exp_rd_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_byte(16'h6000 + 16'(i), 16'h8500 + 16'(i), 1'b1, 3, 1'b1);
    end
    hdma_rd = 1'b0;
    repeat (4) step();
    @(negedge clk);
    n_cmp++;
    if (overrun !== 1'b0 || exp_wr_q.size() != 0 || bytes_done !== 12'h005) begin
      n_bad++;
      $display("FAIL back_to_back: got ov=%b bd=%h, %0d writes outstanding, required 0 005, 0",
               overrun, bytes_done, exp_wr_q.size());
      exp_wr_q.delete(); exp_rd_q.delete();
    end
  endtask

`ifdef GBC_VRAM_MODE3_LOCK_EN
  task automatic test_mode3_lock();
    lcd_mode = 2'b11;
    hdma_active = 1'b1;
    drive_byte(16'h7000, 16'h8600, 1'b0, 4, 1'b0);
    hdma_rd = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if (dropped_writes !== 8'd1 || bytes_done !== 12'h001) begin
      n_bad++;
      $display("FAIL mode3_lock: got dropped=%0d bd=%h, required 1 001", dropped_writes, bytes_done);
    end
    lcd_mode = 2'b00;
    hdma_active = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_gdma();
    test_echo_and_vram_src();
    test_hblank_restart();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
`ifdef GBC_VRAM_MODE3_LOCK_EN
    test_mode3_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
